// File: rtl/fir_scale_shifter.sv
// Two-stage pipelined power-of-two scaler for the FIR datapath: left shift with
// optional saturation, arithmetic right shift with optional round-half-up.
`timescale 1ns/1ps

module fir_scale_shifter #(
  parameter int DATA_WIDTH  = 21,
  parameter int SHIFT_WIDTH = 3,
  parameter int SAT_EN      = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic [SHIFT_WIDTH-1:0]       shift_cnt,
  input  logic                         shift_dir,
  input  logic                         round_en,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_ovf,
  input  logic                         ovf_clr,
  output logic [CNT_WIDTH-1:0]         ovf_count
);

  localparam int W = DATA_WIDTH;
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  // Left shift: overflow is detected by undoing the shift and comparing, which
  // is the same as requiring the sign bit and every shifted-out bit to agree.
  function automatic logic [W:0] shl_sat(input logic signed [W-1:0] d,
                                         input logic [SHIFT_WIDTH-1:0] n);
    logic signed [W-1:0] r;
    logic signed [W-1:0] back;
    logic                ovf;
    r    = d <<< n;
    back = r >>> n;
    ovf  = (back != d);
    if (ovf && (SAT_EN != 0))
      r = d[W-1] ? SMIN : SMAX;
    return {ovf, r};
  endfunction

  // Right shift with round-half-up; one guard bit keeps the rounding add exact.
  function automatic logic signed [W-1:0] shr_rnd(input logic signed [W-1:0] d,
                                                  input logic [SHIFT_WIDTH-1:0] n,
                                                  input logic rnd);
    logic signed [W:0] ext;
    logic signed [W:0] half;
    logic signed [W:0] sum;
    ext  = {d[W-1], d};
    half = '0;
    if (rnd && (n != '0))
      half = {{W{1'b0}}, 1'b1} << (n - 1'b1);
    sum = (ext + half) >>> n;
    return sum[W-1:0];
  endfunction

  logic                   adv1;
  logic                   adv2;

  logic                   vld_p1;
  logic signed [W-1:0]    data_p1;
  logic [SHIFT_WIDTH-1:0] n_p1;
  logic                   dir_p1;
  logic                   rnd_p1;

  logic signed [W-1:0]    res_p1;
  logic                   ovf_p1;
  logic [W:0]             shl_p1;

  logic                   vld_p2;
  logic signed [W-1:0]    data_p2;
  logic                   ovf_p2;
  logic [CNT_WIDTH-1:0]   cnt;

  assign adv2   = !vld_p2 || out_rdy;
  assign adv1   = !vld_p1 || adv2;
  assign in_rdy = adv1;

  // ---- S1: capture sample and its shift controls ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      n_p1    <= '0;
      dir_p1  <= 1'b0;
      rnd_p1  <= 1'b0;
    end else if (adv1) begin
      vld_p1 <= in_vld;
      if (in_vld) begin
        data_p1 <= in_data;
        n_p1    <= shift_cnt;
        dir_p1  <= shift_dir;
        rnd_p1  <= round_en;
      end
    end
  end

  always_comb begin
    shl_p1 = shl_sat(data_p1, n_p1);
    res_p1 = '0;
    ovf_p1 = 1'b0;
    if (dir_p1) begin
      res_p1 = shr_rnd(data_p1, n_p1, rnd_p1);
    end else begin
      res_p1 = shl_p1[W-1:0];
      ovf_p1 = shl_p1[W];
    end
  end

  // ---- S2: registered result drives the output port ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      ovf_p2  <= 1'b0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= res_p1;
        ovf_p2  <= ovf_p1;
      end else begin
        ovf_p2  <= 1'b0;
      end
    end
  end

  // Counts accepted overflowed outputs; clear has priority, never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (ovf_clr)
      cnt <= '0;
    else if (vld_p2 && out_rdy && ovf_p2 && (cnt != {CNT_WIDTH{1'b1}}))
      cnt <= cnt + 1'b1;
  end

  assign out_vld   = vld_p2;
  assign out_data  = data_p2;
  assign out_ovf   = ovf_p2;
  assign ovf_count = cnt;

endmodule

// File: tb/tb_fir_scale_shifter.sv
// Bench for fir_scale_shifter: saturating and wrapping instances share stimulus and
// are scored against an integer-arithmetic reference model.
`timescale 1ns/1ps

module tb_fir_scale_shifter;

  localparam int W = 21;
  localparam int SW = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] shift_cnt = '0;
  logic          shift_dir = 1'b0;
  logic          round_en = 1'b0;
  logic          out_rdy = 1'b1;
  logic          ovf_clr = 1'b0;

  logic          in_rdy, out_vld, out_ovf;
  logic [W-1:0]  out_data;
  logic [CW-1:0] ovf_count;
  logic          w_in_rdy, w_out_vld, w_out_ovf;
  logic [W-1:0]  w_out_data;
  logic [CW-1:0] w_ovf_count;

  always #5 clk = ~clk;

  fir_scale_shifter #(.DATA_WIDTH(W), .SHIFT_WIDTH(SW), .SAT_EN(1), .CNT_WIDTH(CW)) u_sat (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .shift_cnt(shift_cnt), .shift_dir(shift_dir), .round_en(round_en),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_ovf(out_ovf),
    .ovf_clr(ovf_clr), .ovf_count(ovf_count));

  fir_scale_shifter #(.DATA_WIDTH(W), .SHIFT_WIDTH(SW), .SAT_EN(0), .CNT_WIDTH(CW)) u_wrap (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(w_in_rdy), .in_data(in_data),
    .shift_cnt(shift_cnt), .shift_dir(shift_dir), .round_en(round_en),
    .out_vld(w_out_vld), .out_rdy(out_rdy), .out_data(w_out_data), .out_ovf(w_out_ovf),
    .ovf_clr(ovf_clr), .ovf_count(w_ovf_count));

  typedef struct {
    logic [W-1:0] sat;
    logic [W-1:0] wrap;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   cnt_m = 0;
  int   errors = 0;
  int   checks = 0;
  logic         stall_seen = 1'b0;
  logic [W-1:0] stall_data = '0;
  logic         stall_ovf = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Plain integer scaling: multiply or floor-divide by 2^n.
  function automatic exp_t ref_model(input logic [W-1:0] x, input int n,
                                     input logic dir, input logic rnd);
    exp_t   e;
    longint v, p, d, t, q, vmax, vmin;
    v    = longint'($signed(x));
    vmax = (longint'(1) <<< (W-1)) - 1;
    vmin = -(longint'(1) <<< (W-1));
    if (!dir) begin
      p      = v * (longint'(1) <<< n);
      e.ovf  = (p > vmax) || (p < vmin);
      e.wrap = p[W-1:0];
      e.sat  = e.ovf ? ((v < 0) ? vmin[W-1:0] : vmax[W-1:0]) : p[W-1:0];
    end else begin
      d = longint'(1) <<< n;
      t = v + ((rnd && n > 0) ? d / 2 : 0);
      q = t / d;
      if ((t % d) != 0 && t < 0) q = q - 1;
      e.sat  = q[W-1:0];
      e.wrap = q[W-1:0];
      e.ovf  = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard and counter model, evaluated mid-cycle for the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      exp_t e;
      logic got_ovf_xfer;
      got_ovf_xfer = 1'b0;
      if (stall_seen) begin
        check_eq("hold_vld", {31'b0, out_vld}, 1);
        check_eq("hold_data", {11'b0, out_data}, {11'b0, stall_data});
        check_eq("hold_ovf", {31'b0, out_ovf}, {31'b0, stall_ovf});
      end
      if (in_vld && in_rdy)
        sb.push_back(ref_model(in_data, int'(shift_cnt), shift_dir, round_en));
      if (out_vld && out_rdy) begin
        check_eq("sb_extra", {31'b0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("sat_data", {11'b0, out_data}, {11'b0, e.sat});
          check_eq("sat_ovf", {31'b0, out_ovf}, {31'b0, e.ovf});
          check_eq("wrap_data", {11'b0, w_out_data}, {11'b0, e.wrap});
          check_eq("wrap_ovf", {31'b0, w_out_ovf}, {31'b0, e.ovf});
          got_ovf_xfer = e.ovf;
        end
      end
      if (ovf_clr) cnt_m = 0;
      else if (got_ovf_xfer && cnt_m < 65535) cnt_m++;
      stall_seen = out_vld && !out_rdy;
      stall_data = out_data;
      stall_ovf  = out_ovf;
    end
  end

  task automatic send(input logic [W-1:0] x, input int n, input logic dir, input logic rnd);
    logic ok;
    int   k;
    in_vld = 1'b1; in_data = x; shift_cnt = SW'(n); shift_dir = dir; round_en = rnd;
    k = 0;
    forever begin
      @(negedge clk);
      ok = in_rdy;
      @(posedge clk); #1;
      if (ok) break;
      k++;
      if (k > 100) begin
        check_eq("send_timeout", 0, 1);
        break;
      end
    end
    in_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    cnt_m = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [31:0] r;
    r = $urandom;
    case (r[31:30])
      2'd0:    return {{(W-9){r[8]}}, r[8:0]};
      2'd1:    return r[W-1:0];
      2'd2:    return {r[29], ~r[29], r[28:24], 14'h0} ^ {14'h0, r[6:0]};
      default: case (r[1:0])
                 2'd0:    return 21'h100000;
                 2'd1:    return 21'h0FFFFF;
                 2'd2:    return 21'h1FFFFF;
                 default: return 21'h0C0000;
               endcase
    endcase
  endfunction

  logic [W-1:0] tx  [7] = '{21'h000005, 21'h0C0000, 21'h100000, 21'h000006, 21'h000006, 21'h1FFFFF, 21'h0FFFFF};
  int           tn  [7] = '{3, 1, 1, 2, 2, 2, 7};
  logic         td  [7] = '{0, 0, 0, 1, 1, 1, 1};
  logic         trd [7] = '{0, 0, 0, 0, 1, 0, 1};
  logic [W-1:0] tsat[7] = '{21'h000028, 21'h0FFFFF, 21'h100000, 21'h000001, 21'h000002, 21'h1FFFFF, 21'h002000};
  logic [W-1:0] twr [7] = '{21'h000028, 21'h180000, 21'h000000, 21'h000001, 21'h000002, 21'h1FFFFF, 21'h002000};
  logic         tovf[7] = '{0, 1, 1, 0, 0, 0, 0};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t         bexp[4];
    logic [W-1:0] bx[4];
    int           bn[4];

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_vld", {31'b0, out_vld}, 0);
    check_eq("rst_out_data", {11'b0, out_data}, 0);
    check_eq("rst_out_ovf", {31'b0, out_ovf}, 0);
    check_eq("rst_ovf_count", {16'b0, ovf_count}, 0);
    rst = 1'b0;
    #1 check_eq("rst_in_rdy", {31'b0, in_rdy}, 1);
    @(posedge clk); #1;

    // Directed vectors with exact latency checks.
    for (int i = 0; i < 7; i++) begin
      send(tx[i], tn[i], td[i], trd[i]);
      check_eq("lat_early", {31'b0, out_vld}, 0);
      @(posedge clk); #1;
      check_eq("lat_vld", {31'b0, out_vld}, 1);
      check_eq("dir_sat", {11'b0, out_data}, {11'b0, tsat[i]});
      check_eq("dir_wrap", {11'b0, w_out_data}, {11'b0, twr[i]});
      check_eq("dir_ovf", {31'b0, out_ovf}, {31'b0, tovf[i]});
      @(posedge clk); #1;
    end

    // Backpressure: two buffered, two waiting, then drain in order.
    for (int i = 0; i < 4; i++) begin
      bx[i] = rand_data();
      bn[i] = $urandom_range(0, 7);
      bexp[i] = ref_model(bx[i], bn[i], 1'b0, 1'b0);
    end
    out_rdy = 1'b0;
    in_vld = 1'b1; shift_dir = 1'b0; round_en = 1'b0;
    in_data = bx[0]; shift_cnt = SW'(bn[0]);
    @(posedge clk); #1;
    in_data = bx[1]; shift_cnt = SW'(bn[1]);
    @(posedge clk); #1;
    in_data = bx[2]; shift_cnt = SW'(bn[2]);
    check_eq("bp_in_rdy", {31'b0, in_rdy}, 0);
    check_eq("bp_out_vld", {31'b0, out_vld}, 1);
    check_eq("bp_out_a", {11'b0, out_data}, {11'b0, bexp[0].sat});
    repeat (3) @(posedge clk);
    #1;
    check_eq("bp_still_a", {11'b0, out_data}, {11'b0, bexp[0].sat});
    check_eq("bp_still_blocked", {31'b0, in_rdy}, 0);
    out_rdy = 1'b1;
    #1 check_eq("bp_rel_a", {11'b0, out_data}, {11'b0, bexp[0].sat});
    @(posedge clk); #1;
    in_data = bx[3]; shift_cnt = SW'(bn[3]);
    check_eq("bp_rel_b", {11'b0, out_data}, {11'b0, bexp[1].sat});
    @(posedge clk); #1;
    in_vld = 1'b0;
    check_eq("bp_rel_c", {11'b0, out_data}, {11'b0, bexp[2].sat});
    @(posedge clk); #1;
    check_eq("bp_rel_d", {11'b0, out_data}, {11'b0, bexp[3].sat});
    @(posedge clk); #1;
    check_eq("bp_empty", {31'b0, out_vld}, 0);

    // Overflow counter with clear-over-increment priority.
    do_reset();
    for (int i = 0; i < 3; i++) send(21'h0C0000, 1, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("cnt3", {16'b0, ovf_count}, 3);
    check_eq("cnt3_wrap", {16'b0, w_ovf_count}, 3);
    send(21'h0C0000, 1, 1'b0, 1'b0);
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check_eq("cnt_clr_wins", {16'b0, ovf_count}, 0);

    // Randomized traffic with random stalls and clears.
    for (int c = 0; c < 3000; c++) begin
      in_vld    = ($urandom % 4) != 0;
      out_rdy   = ($urandom % 3) != 0;
      ovf_clr   = ($urandom % 50) == 0;
      in_data   = rand_data();
      shift_cnt = SW'($urandom_range(0, 7));
      shift_dir = $urandom % 2;
      round_en  = $urandom % 2;
      @(posedge clk); #1;
    end
    in_vld = 1'b0; out_rdy = 1'b1; ovf_clr = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rand_drain", sb.size(), 0);
    check_eq("rand_cnt", {16'b0, ovf_count}, cnt_m);
    check_eq("rand_cnt_wrap", {16'b0, w_ovf_count}, cnt_m);

    // Long overflow run to reach counter saturation.
    in_vld = 1'b1; in_data = 21'h0C0000; shift_cnt = 3'd1; shift_dir = 1'b0; round_en = 1'b0;
    repeat (65600) @(posedge clk);
    #1 in_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("cnt_sat", {16'b0, ovf_count}, 32'h0000FFFF);
    check_eq("cnt_sat_wrap", {16'b0, w_ovf_count}, 32'h0000FFFF);
    check_eq("cnt_sat_model", cnt_m, 65535);

    // Asynchronous reset with both stages occupied.
    out_rdy = 1'b0;
    send(21'h0C0000, 1, 1'b0, 1'b0);
    send(21'h000123, 2, 1'b0, 1'b0);
    check_eq("mid_full", {31'b0, out_vld}, 1);
    #2 rst = 1'b1;
    sb.delete();
    cnt_m = 0;
    #1;
    check_eq("mid_rst_vld", {31'b0, out_vld}, 0);
    check_eq("mid_rst_data", {11'b0, out_data}, 0);
    check_eq("mid_rst_ovf", {31'b0, out_ovf}, 0);
    check_eq("mid_rst_cnt", {16'b0, ovf_count}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check_eq("post_rst_vld", {31'b0, out_vld}, 0);
      @(posedge clk); #1;
    end
    check_eq("post_rst_rdy", {31'b0, in_rdy}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
